genome_phase_sequencer: RTL and testbench
=========================================

// Module: genome_phase_sequencer
// PURPOSE
// Runs one kernel invocation as up to NUM_PHASES back-to-back DMA phases (e.g. header, then body).
// Each phase: base+offset address, own byte count; one start pulse fans out to NUM_ENGINES
// read/write engines. Waits for every engine's done before advancing. Drives kernel ap_idle/ap_done.
// Replaces the hard-wired 2-state header/body sequencing in the top wrapper.
// PARAMETERS
// NUM_PHASES     4        max phases per invocation (>=1)
// NUM_ENGINES    2        engines whose done must all be seen per phase (>=1)
// ADDR_W         64       address width
// SIZE_W         32       transfer-size width (bytes)
// TIMEOUT_W      24       phase watchdog counter width; all-ones count = timeout
// PORTS
// ap_clk         in   1                  clock
// areset         in   1                  sync reset, active-high
// ap_start       in   1                  level; rising edge while idle launches a run
// ap_idle        out  1                  high when no run active
// ap_done        out  1                  1-cycle pulse at end of run
// base_addr      in   ADDR_W             buffer base
// phase_cnt      in   $clog2(NUM_PHASES+1) phases to run this invocation
// phase_offset   in   NUM_PHASES*ADDR_W  per-phase offset, phase i at [i*ADDR_W +: ADDR_W]
// phase_size     in   NUM_PHASES*SIZE_W  per-phase byte count, same packing
// eng_start      out  1                  1-cycle start pulse to all engines
// eng_addr       out  ADDR_W             current phase address, stable from eng_start until advance
// eng_size       out  SIZE_W             current phase size, same stability
// eng_done       in   NUM_ENGINES        per-engine done pulses/levels
// phase_idx      out  $clog2(NUM_PHASES) index of current/last phase
// err            out  1                  sticky until next launch: clamp or timeout occurred
// BEHAVIOUR
// - Reset: state IDLE; ap_idle=1, ap_done=0, eng_start=0, eng_addr=0, eng_size=0, phase_idx=0, err=0,
//   done-accumulator=0, watchdog=0. Reset mid-run aborts immediately; eng_done ignored.
// - Start detect: ap_start registered; launch only when ap_start=1, ap_start_q=0, state IDLE.
//   Held-high ap_start never relaunches; edges while busy ignored.
// - On launch: latch base_addr, phase_cnt, phase_offset, phase_size (later input changes have no
//   effect); ap_idle<=0; err<=0; phase_idx<=0. phase_cnt>NUM_PHASES: clamp to NUM_PHASES, err<=1.
// - FSM: IDLE -> LOAD -> LAUNCH -> WAIT -> (LOAD | FINISH) -> IDLE.
//   LOAD: eng_addr<=base+offset[idx] (mod 2^ADDR_W, carry dropped), eng_size<=size[idx];
//         clear done-accumulator and watchdog. size==0: skip phase, no eng_start (go NEXT).
//   LAUNCH: eng_start=1 exactly one cycle.
//   WAIT: acc<=acc|eng_done each cycle; done pulses in the LAUNCH cycle are discarded.
//         All bits set -> advance next cycle. Watchdog increments; all-ones -> err<=1, FINISH.
//   Advance: idx+1<latched cnt -> LOAD with idx+1, else FINISH.
//   FINISH: ap_done=1 one cycle, ap_idle<=1, -> IDLE.
// - phase_cnt==0: LOAD skipped, FINISH the cycle after launch (ap_done 2 cycles after edge).
// - Latency per non-empty phase: edge->eng_start = 3 cycles (detect, LOAD, LAUNCH); last done->next
//   eng_start = 3 cycles; last done->ap_done = 2 cycles.
// - Engines assert done in any order, as pulse or level; one high cycle per engine suffices.
// TESTING
// 1 cnt=2, base=0x1000, off={0,0x100}, size={4,256}, engines done 10 cycles after each start ->
//   two eng_start pulses, addr 0x1000/4 then 0x1100/256, one ap_done, ap_idle back to 1.
// 2 NUM_ENGINES=2, engine1 done 5 cycles before engine0 -> no advance until engine0 done;
//   ap_start held high throughout -> no second run.
// 3 cnt=3, size[1]=0 -> eng_start only for phases 0 and 2; phase_idx 0 then 2; err=0.
// 4 cnt=7 with NUM_PHASES=4 -> 4 phases run, err=1; next run with cnt=1 clears err.
// 5 base=0xFFFF_FFFF_FFFF_FF00, off=0x200 -> eng_addr=0x100; cnt=0 -> ap_done 2 cycles after edge.
// 6 TIMEOUT_W=4, engines silent -> err=1, ap_done after 15 WAIT cycles; areset mid-WAIT -> all
//   outputs at reset values next cycle, late eng_done ignored.

Source files
------------

// File: rtl/genome_phase_sequencer.sv
// Multi-phase DMA sequencer: runs up to NUM_PHASES back-to-back engine phases per kernel
// invocation, waiting on every engine's done (with a watchdog) before advancing.
module genome_phase_sequencer #(
  parameter int NUM_PHASES  = 4,
  parameter int NUM_ENGINES = 2,
  parameter int ADDR_W      = 64,
  parameter int SIZE_W      = 32,
  parameter int TIMEOUT_W   = 24,
  localparam int CNT_W = $clog2(NUM_PHASES + 1),
  localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                         ap_clk,
  input  logic                         areset,
  input  logic                         ap_start,
  output logic                         ap_idle,
  output logic                         ap_done,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [CNT_W-1:0]             phase_cnt,
  input  logic [NUM_PHASES*ADDR_W-1:0] phase_offset,
  input  logic [NUM_PHASES*SIZE_W-1:0] phase_size,
  output logic                         eng_start,
  output logic [ADDR_W-1:0]            eng_addr,
  output logic [SIZE_W-1:0]            eng_size,
  input  logic [NUM_ENGINES-1:0]       eng_done,
  output logic [IDX_W-1:0]             phase_idx,
  output logic                         err
);

  localparam int NW = CNT_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_PHASES);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LAUNCH, S_WAIT, S_FINISH} state_t;

  state_t                 state_q, state_d;
  logic                   ap_start_q;
  logic                   ap_idle_q, ap_done_q, eng_start_q;
  logic [ADDR_W-1:0]      eng_addr_q, eng_addr_d;
  logic [SIZE_W-1:0]      eng_size_q, eng_size_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   err_q, err_d;
  logic [NUM_ENGINES-1:0] acc_q, acc_d;
  logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [ADDR_W-1:0]      off_q [NUM_PHASES];
  logic [ADDR_W-1:0]      off_d [NUM_PHASES];
  logic [SIZE_W-1:0]      sz_q  [NUM_PHASES];
  logic [SIZE_W-1:0]      sz_d  [NUM_PHASES];
  logic                   launch;
  logic [NW-1:0]          nxt_cnt;
  logic                   more;

  assign launch  = ap_start & ~ap_start_q;
  assign nxt_cnt = NW'(idx_q) + NW'(1);
  assign more    = nxt_cnt < NW'(cnt_q);

  always_comb begin
    state_d    = state_q;
    eng_addr_d = eng_addr_q;
    eng_size_d = eng_size_q;
    idx_d      = idx_q;
    err_d      = err_q;
    acc_d      = acc_q;
    wdog_d     = wdog_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    off_d      = off_q;
    sz_d       = sz_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          base_d = base_addr;
          for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            off_d[i] = phase_offset[i*ADDR_W +: ADDR_W];
            sz_d[i]  = phase_size[i*SIZE_W +: SIZE_W];
          end
          idx_d = '0;
          err_d = 1'b0;
          cnt_d = phase_cnt;
          if (phase_cnt > MAX_CNT) begin
            cnt_d = MAX_CNT;
            err_d = 1'b1;
          end
          state_d = (cnt_d == '0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: begin
        eng_addr_d = base_q + off_q[idx_q];
        eng_size_d = sz_q[idx_q];
        acc_d      = '0;
        wdog_d     = '0;
        // An empty phase advances straight from LOAD without pulsing the engines.
        if (eng_size_d == '0) begin
          if (more) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        acc_d  = acc_q | eng_done;
        wdog_d = wdog_q + TIMEOUT_W'(1);
        if (&acc_d) begin
          if (more) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end else begin
            state_d = S_FINISH;
          end
        end else if (&wdog_d) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      ap_start_q  <= 1'b0;
      ap_idle_q   <= 1'b1;
      ap_done_q   <= 1'b0;
      eng_start_q <= 1'b0;
      eng_addr_q  <= '0;
      eng_size_q  <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      wdog_q      <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      off_q       <= '{default: '0};
      sz_q        <= '{default: '0};
    end else begin
      state_q     <= state_d;
      ap_start_q  <= ap_start;
      ap_idle_q   <= (state_d == S_IDLE);
      ap_done_q   <= (state_d == S_FINISH);
      eng_start_q <= (state_d == S_LAUNCH);
      eng_addr_q  <= eng_addr_d;
      eng_size_q  <= eng_size_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      wdog_q      <= wdog_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      off_q       <= off_d;
      sz_q        <= sz_d;
    end
  end

  assign ap_idle   = ap_idle_q;
  assign ap_done   = ap_done_q;
  assign eng_start = eng_start_q;
  assign eng_addr  = eng_addr_q;
  assign eng_size  = eng_size_q;
  assign phase_idx = idx_q;
  assign err       = err_q;

endmodule

// File: tb/tb_genome_phase_sequencer.sv
// Directed bench for genome_phase_sequencer (4 phases, 2 engines, 4-bit watchdog).
module tb_genome_phase_sequencer;

  localparam int NP = 4;
  localparam int NE = 2;
  localparam int AW = 64;
  localparam int SW = 32;

  logic             ap_clk;
  logic             areset;
  logic             ap_start;
  logic             ap_idle;
  logic             ap_done;
  logic [AW-1:0]    base_addr;
  logic [2:0]       phase_cnt;
  logic [NP*AW-1:0] phase_offset;
  logic [NP*SW-1:0] phase_size;
  logic             eng_start;
  logic [AW-1:0]    eng_addr;
  logic [SW-1:0]    eng_size;
  logic [NE-1:0]    eng_done;
  logic [1:0]       phase_idx;
  logic             err;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  genome_phase_sequencer #(
    .NUM_PHASES (NP),
    .NUM_ENGINES(NE),
    .ADDR_W     (AW),
    .SIZE_W     (SW),
    .TIMEOUT_W  (4)
  ) dut (
    .ap_clk      (ap_clk),
    .areset      (areset),
    .ap_start    (ap_start),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .base_addr   (base_addr),
    .phase_cnt   (phase_cnt),
    .phase_offset(phase_offset),
    .phase_size  (phase_size),
    .eng_start   (eng_start),
    .eng_addr    (eng_addr),
    .eng_size    (eng_size),
    .eng_done    (eng_done),
    .phase_idx   (phase_idx),
    .err         (err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed hang expected $finish");
    $fatal(1, "bench time limit expired");
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_phase(input int i, input logic [63:0] off, input logic [31:0] sz);
    phase_offset[i*AW +: AW] = off;
    phase_size[i*SW +: SW]   = sz;
  endtask

  // Ticks until eng_start is seen (bounded) and checks how many ticks it took.
  task automatic wait_start(input string tag, input int exp_n);
    int n;
    n = 0;
    while (eng_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_n));
  endtask

  // Called in the eng_start cycle; engine k pulses done dk ticks later.
  task automatic drive_done(input int d0, input int d1, input int exp_idx);
    int m;
    m = (d0 > d1) ? d0 : d1;
    for (int k = 1; k <= m; k++) begin
      tick();
      if (k == m)
        chk("no_early_advance", {60'd0, ap_idle, ap_done, eng_start, 1'b0} | 64'(phase_idx),
            64'(exp_idx));
      eng_done = {(k == d1), (k == d0)};
    end
    tick();
    eng_done = '0;
  endtask

  initial begin
    logic seen;
    areset       = 1'b1;
    ap_start     = 1'b0;
    base_addr    = '0;
    phase_cnt    = '0;
    phase_offset = '0;
    phase_size   = '0;
    eng_done     = '0;
    tick();
    tick();
    chk("rst_idle_done_start", {ap_idle, ap_done, eng_start, err}, 4'b1000);
    chk("rst_addr", eng_addr, 64'h0);
    chk("rst_size_idx", {eng_size, 30'd0, phase_idx}, 64'h0);
    areset = 1'b0;
    tick();

    // Two-phase run; inputs change after launch and must not matter.
    base_addr = 64'h1000; phase_cnt = 3'd2;
    set_phase(0, 64'h0, 32'd4); set_phase(1, 64'h100, 32'd256);
    set_phase(2, 64'h5555, 32'd9); set_phase(3, 64'h7777, 32'd9);
    ap_start = 1'b1;
    wait_start("t1_lat0", 2);
    chk("t1_idle_low", ap_idle, 0);
    chk("t1_addr0", eng_addr, 64'h1000);
    chk("t1_size0_idx", {eng_size, 30'd0, phase_idx}, {32'd4, 32'd0});
    base_addr = 64'hDEAD_0000; set_phase(1, 64'h999, 32'd1); phase_cnt = 3'd1;
    ap_start = 1'b0;
    drive_done(9, 9, 0);
    wait_start("t1_lat1", 1);
    chk("t1_addr1", eng_addr, 64'h1100);
    chk("t1_size1_idx", {eng_size, 30'd0, phase_idx}, {32'd256, 32'd1});
    drive_done(9, 9, 1);
    chk("t1_done", {ap_done, ap_idle, eng_start}, 3'b100);
    tick();
    chk("t1_back_idle", {ap_done, ap_idle}, 2'b01);

    // Engine 1 finishes 5 cycles before engine 0; ap_start stays high.
    base_addr = 64'h2000; phase_cnt = 3'd1; set_phase(0, 64'h40, 32'd8);
    ap_start = 1'b1;
    wait_start("t2_lat", 2);
    chk("t2_addr", eng_addr, 64'h2040);
    drive_done(8, 3, 0);
    chk("t2_done", ap_done, 1);
    tick();
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | eng_start | ~ap_idle;
    end
    chk("t2_no_relaunch", seen, 0);
    ap_start = 1'b0;
    tick();

    // Middle phase empty: skipped without an engine start.
    base_addr = 64'h3000; phase_cnt = 3'd3;
    set_phase(0, 64'h0, 32'd16); set_phase(1, 64'h10, 32'd0); set_phase(2, 64'h20, 32'd32);
    ap_start = 1'b1;
    wait_start("t3_lat0", 2);
    chk("t3_idx0", phase_idx, 0);
    ap_start = 1'b0;
    drive_done(2, 2, 0);
    wait_start("t3_lat2", 2);
    chk("t3_idx2", phase_idx, 2);
    chk("t3_addr2", {eng_addr[31:0], eng_size}, {32'h3020, 32'd32});
    drive_done(2, 2, 2);
    chk("t3_done_noerr", {ap_done, err}, 2'b10);
    tick();

    // Phase count above maximum: clamped to four phases, err raised.
    base_addr = 64'h4000; phase_cnt = 3'd7;
    for (int p = 0; p < NP; p++) set_phase(p, 64'(p) * 64'h1000, 32'(p + 1));
    ap_start = 1'b1;
    wait_start("t4_lat0", 2);
    chk("t4_err_set", err, 1);
    ap_start = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (p > 0) wait_start("t4_lat", 1);
      chk("t4_addr", eng_addr, 64'h4000 + 64'(p) * 64'h1000);
      chk("t4_size_idx", {eng_size, 30'd0, phase_idx}, {32'(p + 1), 32'(p)});
      drive_done(1, 1, p);
    end
    chk("t4_done_err", {ap_done, err, 30'd0, phase_idx}, {1'b1, 1'b1, 32'd3});
    tick();
    base_addr = 64'h5000; phase_cnt = 3'd1; set_phase(0, 64'h0, 32'd5);
    ap_start = 1'b1;
    wait_start("t4b_lat", 2);
    chk("t4b_err_clear", err, 0);
    ap_start = 1'b0;
    drive_done(1, 1, 0);
    chk("t4b_done", ap_done, 1);
    tick();

    // Address wraps modulo 2^64.
    base_addr = 64'hFFFF_FFFF_FFFF_FF00; phase_cnt = 3'd1; set_phase(0, 64'h200, 32'd9);
    ap_start = 1'b1;
    wait_start("t5_lat", 2);
    chk("t5_wrap_addr", eng_addr, 64'h100);
    ap_start = 1'b0;
    drive_done(1, 1, 0);
    chk("t5_done", ap_done, 1);
    tick();

    // Zero phases: done without any engine start.
    phase_cnt = 3'd0;
    ap_start = 1'b1;
    chk("t5z_pre", {ap_done, ap_idle}, 2'b01);
    tick();
    chk("t5z_done", {ap_done, ap_idle, eng_start}, 3'b100);
    tick();
    chk("t5z_idle", {ap_done, ap_idle, eng_start}, 3'b010);
    ap_start = 1'b0;
    tick();

    // Silent engines: watchdog expires after 15 WAIT cycles.
    base_addr = 64'h6000; phase_cnt = 3'd2;
    set_phase(0, 64'h0, 32'd7); set_phase(1, 64'h80, 32'd8);
    ap_start = 1'b1;
    wait_start("t6_lat", 2);
    ap_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      seen = seen | ap_done | eng_start;
    end
    chk("t6_no_early_done", seen, 0);
    tick();
    chk("t6_timeout_done", {ap_done, err, 30'd0, phase_idx}, {1'b1, 1'b1, 32'd0});
    tick();
    chk("t6_idle", ap_idle, 1);

    // Reset mid-WAIT in phase 1 of a clamped run.
    base_addr = 64'h7000; phase_cnt = 3'd7;
    for (int p = 0; p < NP; p++) set_phase(p, 64'(p) * 64'h10, 32'(p + 1));
    ap_start = 1'b1;
    wait_start("t7_lat0", 2);
    ap_start = 1'b0;
    drive_done(1, 1, 0);
    wait_start("t7_lat1", 1);
    chk("t7_pre_rst", {err, 30'd0, phase_idx}, {1'b1, 32'd1});
    tick();
    tick();
    areset = 1'b1;
    tick();
    chk("t7_rst_flags", {ap_idle, ap_done, eng_start, err}, 4'b1000);
    chk("t7_rst_addr", eng_addr, 64'h0);
    chk("t7_rst_size_idx", {eng_size, 30'd0, phase_idx}, 64'h0);
    areset = 1'b0;
    eng_done = 2'b11;
    tick();
    eng_done = '0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen = seen | ap_done | eng_start | ~ap_idle;
    end
    chk("t7_late_done_ignored", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
